// File: rtl/pipe_stage_skid.sv
// Two-entry valid/ready pipeline stage (main + skid register), 1-cycle latency.
// ready_o comes from registered state only; a second entry is absorbed while downstream stalls.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic              accept;
  logic              pop;
  logic              main_ld_in;
  logic              main_ld_skid;
  logic              skid_ld;

  assign ready_o     = (state != TWO);
  assign valid_o     = (state != EMPTY);
  assign accept      = valid_i && ready_o;
  assign pop         = valid_o && ready_i;
  assign ctrl_o      = valid_o ? main_ctrl : '0;
  assign data_o      = main_data;
  assign stall_cnt_o = stall_cnt;

  always_comb begin
    count_o = 2'd0;
    case (state)
      ONE:     count_o = 2'd1;
      TWO:     count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush_i) begin
      // Flush drops everything; register contents stay so data_o keeps its last value.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_ld_in = 1'b1;
            state_nxt  = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ld_in = 1'b1;
          end else if (accept) begin
            skid_ld   = 1'b1;
            state_nxt = TWO;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_ld_skid = 1'b1;
            state_nxt    = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (main_ld_in) begin
        main_ctrl <= ctrl_i;
        main_data <= data_i;
      end else if (main_ld_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (skid_ld) begin
        skid_ctrl <= ctrl_i;
        skid_data <= data_i;
      end
      // Back-pressure counter survives flush and sticks at its maximum.
      if (valid_o && !ready_i && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, saturation/reset sequence, random vs queue model.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        vld;
  logic [3:0]  ctrl;
  logic [15:0] data;
  logic        rdy;

  logic        ready_o, valid_o;
  logic [3:0]  ctrl_o;
  logic [15:0] data_o;
  logic [1:0]  count_o;
  logic [15:0] stall_o;

  logic        s_ready_o, s_valid_o;
  logic [3:0]  s_ctrl_o;
  logic [15:0] s_data_o;
  logic [1:0]  s_count_o;
  logic [1:0]  s_stall_o;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vld), .ready_o(ready_o),
    .ctrl_i(ctrl), .data_i(data), .valid_o(valid_o), .ready_i(rdy),
    .ctrl_o(ctrl_o), .data_o(data_o), .count_o(count_o), .stall_cnt_o(stall_o)
  );

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(4), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vld), .ready_o(s_ready_o),
    .ctrl_i(ctrl), .data_i(data), .valid_o(s_valid_o), .ready_i(rdy),
    .ctrl_o(s_ctrl_o), .data_o(s_data_o), .count_o(s_count_o), .stall_cnt_o(s_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, flush, vld;
    logic [3:0]  c;
    logic [15:0] d;
    logic        rdy;
    int          ecnt;
    logic        evld, erdy;
    logic [15:0] ed;
    logic [3:0]  ec;
    int          est;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic v, input logic [3:0] c,
                     input logic [15:0] d, input logic rd, input int ecnt, input logic evld,
                     input logic erdy, input logic [15:0] ed, input logic [3:0] ec, input int est);
    vec_t t;
    t.rst = r; t.flush = f; t.vld = v; t.c = c; t.d = d; t.rdy = rd;
    t.ecnt = ecnt; t.evld = evld; t.erdy = erdy; t.ed = ed; t.ec = ec; t.est = est;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [3:0] c,
                      input logic [15:0] d, input logic rd);
    rst = r; flush = f; vld = v; ctrl = c; data = d; rdy = rd;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [3:0]  c;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] last_d;
  int          m_stall;

  task automatic model_edge(input logic r, input logic f, input logic v, input logic [3:0] c,
                            input logic [15:0] d, input logic rd);
    ent_t e;
    bit   acc, pp;
    if (r) begin
      q.delete();
      last_d  = '0;
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !rd && m_stall < 65535) m_stall++;
      if (f) begin
        q.delete();
      end else begin
        acc = v && (q.size() < 2);
        pp  = (q.size() > 0) && rd;
        if (pp) void'(q.pop_front());
        if (acc) begin
          e.c = c; e.d = d;
          q.push_back(e);
        end
      end
      if (q.size() > 0) last_d = q[0].d;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(count_o), 32'(q.size()));
    chk({tag, "_valid"}, 32'(valid_o), 32'(q.size() > 0));
    chk({tag, "_ready"}, 32'(ready_o), 32'(q.size() < 2));
    chk({tag, "_data"}, 32'(data_o), 32'(q.size() > 0 ? q[0].d : last_d));
    chk({tag, "_ctrl"}, 32'(ctrl_o), 32'(q.size() > 0 ? q[0].c : 4'd0));
    chk({tag, "_stall"}, 32'(stall_o), 32'(m_stall));
    chk({tag, "_sat_stall"}, 32'(s_stall_o), 32'(m_stall > 3 ? 3 : m_stall));
    chk({tag, "_sat_data"}, 32'(s_data_o), 32'(data_o));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vld = 1'b0; ctrl = '0; data = '0; rdy = 1'b0;

    //  rst f v  c     d        rdy  cnt vld rdy  data     ctrl  stall
    add(1, 0, 0, 4'h0, 16'h0000, 0,  0,  0,  1,  16'h0000, 4'h0, 0); // reset state
    add(0, 0, 1, 4'h1, 16'h0001, 1,  1,  1,  1,  16'h0001, 4'h1, 0); // streaming 1,2,3
    add(0, 0, 1, 4'h2, 16'h0002, 1,  1,  1,  1,  16'h0002, 4'h2, 0);
    add(0, 0, 1, 4'h3, 16'h0003, 1,  1,  1,  1,  16'h0003, 4'h3, 0);
    add(0, 0, 0, 4'h0, 16'h0000, 1,  0,  0,  1,  16'h0003, 4'h0, 0); // drained, data held
    add(0, 0, 1, 4'h5, 16'h000A, 0,  1,  1,  1,  16'h000A, 4'h5, 0); // back-pressure: A
    add(0, 0, 1, 4'h6, 16'h000B, 0,  2,  1,  0,  16'h000A, 4'h5, 1); // B into skid
    add(0, 0, 1, 4'h7, 16'h000C, 0,  2,  1,  0,  16'h000A, 4'h5, 2); // full, offer refused
    add(0, 0, 0, 4'h0, 16'h0000, 0,  2,  1,  0,  16'h000A, 4'h5, 3);
    add(0, 0, 0, 4'h0, 16'h0000, 1,  1,  1,  1,  16'h000B, 4'h6, 3); // pop A
    add(0, 0, 0, 4'h0, 16'h0000, 1,  0,  0,  1,  16'h000B, 4'h0, 3); // pop B
    add(0, 0, 1, 4'h1, 16'h0011, 0,  1,  1,  1,  16'h0011, 4'h1, 3); // simultaneous in ONE
    add(0, 0, 1, 4'h2, 16'h0022, 1,  1,  1,  1,  16'h0022, 4'h2, 3);
    add(0, 0, 1, 4'h3, 16'h0033, 0,  2,  1,  0,  16'h0022, 4'h2, 4); // fill to TWO
    add(0, 1, 1, 4'h4, 16'h0044, 0,  0,  0,  1,  16'h0022, 4'h0, 5); // flush in TWO
    add(0, 0, 0, 4'h0, 16'h0000, 1,  0,  0,  1,  16'h0022, 4'h0, 5); // nothing emerges
    add(0, 0, 1, 4'h5, 16'h0055, 1,  1,  1,  1,  16'h0055, 4'h5, 5);
    add(0, 1, 1, 4'h6, 16'h0066, 1,  0,  0,  1,  16'h0055, 4'h0, 5); // flush beats accept+pop
    add(0, 0, 0, 4'h0, 16'h0000, 1,  0,  0,  1,  16'h0055, 4'h0, 5);
    add(0, 0, 1, 4'h7, 16'h0077, 0,  1,  1,  1,  16'h0077, 4'h7, 5);
    add(1, 1, 1, 4'h8, 16'h0088, 1,  0,  0,  1,  16'h0000, 4'h0, 0); // reset beats all

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].c, vecs[i].d, vecs[i].rdy);
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].evld));
      chk($sformatf("v%0d_ready", i), 32'(ready_o), 32'(vecs[i].erdy));
      chk($sformatf("v%0d_data", i), 32'(data_o), 32'(vecs[i].ed));
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl_o), 32'(vecs[i].ec));
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].est));
      chk($sformatf("v%0d_sat", i), 32'(s_stall_o), 32'(vecs[i].est > 3 ? 3 : vecs[i].est));
    end

    // Saturation at CNT_W=2, then reset mid-operation.
    step(0, 0, 1, 4'h9, 16'h0099, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'h0, 16'h0000, 0);
    chk("sat_stall3", 32'(s_stall_o), 32'd3);
    chk("wide_stall5", 32'(stall_o), 32'd5);
    chk("sat_data_held", 32'(s_data_o), 32'h0099);
    step(1, 0, 0, 4'h0, 16'h0000, 0);
    chk("rst_sat_stall", 32'(s_stall_o), 32'd0);
    chk("rst_valid", 32'(s_valid_o), 32'd0);
    chk("rst_data", 32'(s_data_o), 32'd0);
    chk("rst_ready", 32'(s_ready_o), 32'd1);
    chk("rst_count", 32'(s_count_o), 32'd0);
    chk("rst_ctrl", 32'(s_ctrl_o), 32'd0);

    // Randomised traffic against the queue model.
    model_edge(1, 0, 0, 4'h0, 16'h0000, 0);
    begin
      int          bias;
      logic        r, f, v, rd;
      logic [3:0]  c;
      logic [15:0] d;
      bias = 2;
      for (int n = 0; n < 3000; n++) begin
        if (n % 150 == 0) bias = int'($urandom_range(0, 4));
        r  = ($urandom_range(0, 299) == 0);
        f  = ($urandom_range(0, 39) == 0);
        v  = ($urandom_range(0, 3) != 0);
        rd = (int'($urandom_range(0, 3)) < bias);
        c  = 4'($urandom);
        d  = 16'($urandom);
        model_edge(r, f, v, c, d, rd);
        step(r, f, v, c, d, rd);
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 128: payload width in bits, minimum 1.
REQ-002 Parameter CTRL_W, default 8: control-bit width in bits, minimum 1; control bits are forced to 0 whenever the stage outputs a bubble.
REQ-003 Parameter CNT_W, default 16: width of the stall-cycle counter, minimum 2.
REQ-004 clk_i  in  1  the only clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 flush_i  in  1  synchronous flush: discard all held entries.
REQ-007 valid_i  in  1  upstream entry present.
REQ-008 ready_o  out  1  stage can accept an entry this cycle.
REQ-009 ctrl_i  in  CTRL_W  upstream control bits (aluOp, memRead, regWrite, etc.).
REQ-010 data_i  in  DATA_W  upstream payload (operands, immediate, register addresses).
REQ-011 valid_o  out  1  downstream entry present.
REQ-012 ready_i  in  1  downstream accepts the entry this cycle.
REQ-013 ctrl_o  out  CTRL_W  held control bits, 0 when valid_o=0.
REQ-014 data_o  out  DATA_W  held payload.
REQ-015 count_o  out  2  occupancy: 0, 1 or 2.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-017 The stage SHALL hold two entries: a main register that drives ctrl_o/data_o and a skid register; the state SHALL be EMPTY, ONE or TWO, with count_o = 0, 1 or 2 respectively.
REQ-018 An accept SHALL occur when valid_i=1 and ready_o=1; a pop SHALL occur when valid_o=1 and ready_i=1.
REQ-019 ready_o SHALL be 1 exactly when the state is not TWO, decoded from registered state only, with no combinational path from ready_i or valid_i.
REQ-020 valid_o SHALL be 1 exactly when the state is not EMPTY.
REQ-021 From EMPTY, an accept SHALL load the main register and move to ONE; valid_o rises on the next cycle, giving a latency of 1 cycle.
REQ-022 From ONE, the transitions SHALL be:
  - accept with no pop: load the skid register, move to TWO;
  - pop with no accept: move to EMPTY;
  - accept and pop together: load the main register from the input, stay in ONE.
REQ-023 From TWO, a pop SHALL copy the skid register into the main register and move to ONE; an accept cannot occur in TWO.
REQ-024 While valid_o=1 and ready_i=0, ctrl_o and data_o SHALL remain stable.
REQ-025 Entries SHALL leave in strict acceptance order, with no loss and no duplication.
REQ-026 When valid_o=0, ctrl_o SHALL be 0 (bubble), and data_o SHALL hold its last value.
REQ-027 A flush (flush_i=1) SHALL take priority over every other event and behave as follows:
  - next state is EMPTY, with ctrl_o=0 and valid_o=0;
  - any accept or pop in the flush cycle is discarded or ignored;
  - ready_o is 1 in the following cycle.
REQ-028 stall_cnt_o SHALL increment by 1 in each cycle where valid_o=1 and ready_i=0, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush_i.

Reset
REQ-029 With rst_i=1 at a clock edge, the stage SHALL enter EMPTY and set:
  - valid_o=0, ctrl_o=0, data_o=0, count_o=0, stall_cnt_o=0;
  - both internal registers cleared.
REQ-030 ready_o SHALL read 1 from the first cycle after reset.
REQ-031 Reset SHALL take priority over flush_i and over any handshake.
REQ-032 A reset asserted mid-operation SHALL discard all held entries with no partial output.

Verification
REQ-033 Streaming: ready_i=1, and entries data_i=1,2,3 are presented on consecutive cycles -> data_o=1,2,3 on the next three cycles, count_o=1 throughout, ready_o=1 throughout.
REQ-034 Back-pressure: ready_i=0 while entries A and B are accepted -> count_o=2, ready_o=0, data_o=A stable, and stall_cnt_o increments each cycle; then ready_i=1 -> A then B are popped and count_o falls 2->1->0.
REQ-035 Simultaneous events in ONE: accept C and pop A in the same cycle -> next cycle data_o=C, count_o=1.
REQ-036 Flush: in TWO, assert flush_i while valid_i=1 -> next cycle valid_o=0, ctrl_o=0, count_o=0, ready_o=1, and the offered entry is never output.
REQ-037 Saturation and reset: CNT_W=2 with 5 stall cycles -> stall_cnt_o=3; a subsequent rst_i=1 -> stall_cnt_o=0, valid_o=0, data_o=0.
